umtrx_packet_framer: RTL and testbench

//  TX-side counterpart of the UmTRX packet dispatcher. Takes VRT frames on a fifo36 stream
//  and prepends a 2-byte-padded Ethernet/IPv4/UDP header (11 words), then forwards the VRT

---
 rtl/umtrx_packet_framer.sv | 174 +++++++++++++++++
 tb/tb_umtrx_packet_framer.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umtrx_packet_framer.sv
// Prepends an 11-word Ethernet/IPv4/UDP header (2-byte padded) to each VRT frame on a
// fifo36 stream. Header fields come from setting registers, snapshotted at VRT word 0.
module umtrx_packet_framer #(
   parameter int BASE = 0,
   parameter int TTL  = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [35:0] vrt_inp_data,
   input  logic        vrt_inp_valid,
   output logic        vrt_inp_ready,
   output logic [35:0] eth_out_data,
   output logic        eth_out_valid,
   input  logic        eth_out_ready
);

   typedef enum logic [2:0] {S_IDLE, S_CSUM, S_HDR, S_FIRST, S_LIVE, S_DROP} state_t;

   localparam logic [7:0]  BASE_A  = 8'(BASE);
   localparam logic [7:0]  TTL_B   = 8'(TTL);
   localparam logic [15:0] MAX_LEN = 16'd16376;
   localparam logic [3:0]  LAST_HW = 4'd10;

   state_t       r_state, w_next;
   logic [3:0]   r_cnt;
   logic [35:0]  r_hold;
   logic [15:0]  r_csum;

   logic [31:0]  r_src_ip, r_dst_ip, r_ports;
   logic [47:0]  r_src_mac, r_dst_mac;
   logic [31:0]  r_snap_src_ip, r_snap_dst_ip, r_snap_ports;
   logic [47:0]  r_snap_src_mac, r_snap_dst_mac;

   logic [7:0]   w_off;
   logic         w_sof_acc, w_bad_len, w_fire;
   logic [15:0]  w_ip_len, w_udp_len;
   logic [19:0]  w_sum;
   logic [16:0]  w_fold1;
   logic [15:0]  w_fold2;
   logic [31:0]  w_hdr;

   assign w_off     = set_addr - BASE_A;
   assign w_sof_acc = (r_state == S_IDLE) && vrt_inp_valid && vrt_inp_data[32] && !clr;
   assign w_bad_len = (vrt_inp_data[15:0] == 16'd0) || (vrt_inp_data[15:0] > MAX_LEN);
   assign w_fire    = eth_out_valid && eth_out_ready;

   // NOTE: every register below is updated with <= so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src_ip  <= '0;
         r_ports   <= '0;
         r_dst_ip  <= '0;
         r_src_mac <= '0;
         r_dst_mac <= '0;
      end else if (set_stb) begin
         case (w_off)
            8'd0:    r_src_ip         <= set_data;
            8'd1:    r_ports          <= set_data;
            8'd2:    r_dst_ip         <= set_data;
            8'd3:    r_src_mac[47:32] <= set_data[15:0];
            8'd4:    r_src_mac[31:0]  <= set_data;
            8'd5:    r_dst_mac[47:32] <= set_data[15:0];
            8'd6:    r_dst_mac[31:0]  <= set_data;
            default: ;
         endcase
      end
   end

   // Lengths are 4 bytes per VRT word; n is bounded so neither sum overflows 16 bits.
   assign w_ip_len  = 16'd28 + (r_hold[15:0] << 2);
   assign w_udp_len = 16'd8  + (r_hold[15:0] << 2);
   assign w_sum     = 20'h04500 + 20'(w_ip_len) + 20'h04000 + 20'({TTL_B, 8'h11})
                    + 20'(r_snap_src_ip[31:16]) + 20'(r_snap_src_ip[15:0])
                    + 20'(r_snap_dst_ip[31:16]) + 20'(r_snap_dst_ip[15:0]);
   assign w_fold1   = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
   assign w_fold2   = w_fold1[15:0] + 16'(w_fold1[16]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_hold         <= '0;
         r_csum         <= '0;
         r_snap_src_ip  <= '0;
         r_snap_dst_ip  <= '0;
         r_snap_ports   <= '0;
         r_snap_src_mac <= '0;
         r_snap_dst_mac <= '0;
      end else begin
         r_state <= clr ? S_IDLE : w_next;
         if (w_sof_acc) begin
            r_hold         <= vrt_inp_data;
            r_snap_src_ip  <= r_src_ip;
            r_snap_dst_ip  <= r_dst_ip;
            r_snap_ports   <= r_ports;
            r_snap_src_mac <= r_src_mac;
            r_snap_dst_mac <= r_dst_mac;
         end
         if (r_state == S_CSUM) begin
            r_csum <= ~w_fold2;
            r_cnt  <= '0;
         end else if (r_state == S_HDR && w_fire) begin
            r_cnt  <= r_cnt + 4'd1;
         end
      end
   end

   always_comb begin
      w_hdr = '0;
      case (r_cnt)
         4'd0:    w_hdr = {16'h0000, r_snap_dst_mac[47:32]};
         4'd1:    w_hdr = r_snap_dst_mac[31:0];
         4'd2:    w_hdr = r_snap_src_mac[47:16];
         4'd3:    w_hdr = {r_snap_src_mac[15:0], 16'h0800};
         4'd4:    w_hdr = {16'h4500, w_ip_len};
         4'd5:    w_hdr = 32'h0000_4000;
         4'd6:    w_hdr = {TTL_B, 8'h11, r_csum};
         4'd7:    w_hdr = r_snap_src_ip;
         4'd8:    w_hdr = r_snap_dst_ip;
         4'd9:    w_hdr = r_snap_ports;
         4'd10:   w_hdr = {w_udp_len, 16'h0000};
         default: w_hdr = '0;
      endcase
   end

   // NOTE: all outputs get a default first so no path through this block infers a latch.
   always_comb begin
      w_next        = r_state;
      vrt_inp_ready = 1'b0;
      eth_out_valid = 1'b0;
      eth_out_data  = '0;
      case (r_state)
         S_IDLE: begin
            vrt_inp_ready = 1'b1;
            if (vrt_inp_valid && vrt_inp_data[32]) begin
               if (w_bad_len) w_next = vrt_inp_data[33] ? S_IDLE : S_DROP;
               else           w_next = S_CSUM;
            end
         end
         S_CSUM: w_next = S_HDR;
         S_HDR: begin
            eth_out_valid = 1'b1;
            eth_out_data  = {3'b000, (r_cnt == 4'd0), w_hdr};
            if (w_fire && r_cnt == LAST_HW) w_next = S_FIRST;
         end
         S_FIRST: begin
            eth_out_valid = 1'b1;
            eth_out_data  = {r_hold[35:33], 1'b0, r_hold[31:0]};
            if (w_fire) w_next = r_hold[33] ? S_IDLE : S_LIVE;
         end
         S_LIVE: begin
            eth_out_valid = vrt_inp_valid;
            vrt_inp_ready = eth_out_ready;
            eth_out_data  = {vrt_inp_data[35:33], 1'b0, vrt_inp_data[31:0]};
            if (vrt_inp_valid && eth_out_ready && vrt_inp_data[33]) w_next = S_IDLE;
         end
         S_DROP: begin
            vrt_inp_ready = 1'b1;
            if (vrt_inp_valid && vrt_inp_data[33]) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // A clear cycle must not complete any handshake on either side.
      if (clr) begin
         vrt_inp_ready = 1'b0;
         eth_out_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_umtrx_packet_framer.sv
// Randomized bench for umtrx_packet_framer: frames are driven with random gaps and
// back-pressure, and the output is compared with a header/frame model built from field rules.
`timescale 1ns/1ps
module tb_umtrx_packet_framer;

   localparam int BASE = 16;
   localparam int TTL  = 64;

   typedef logic [35:0] word_t;
   typedef word_t word_q_t[$];
   typedef struct {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [47:0] src_mac;
      logic [47:0] dst_mac;
   } cfg_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = '0;
   logic [31:0] set_data = '0;
   logic [35:0] vrt_inp_data = '0;
   logic        vrt_inp_valid = 1'b0;
   logic        vrt_inp_ready;
   logic [35:0] eth_out_data;
   logic        eth_out_valid;
   logic        eth_out_ready = 1'b1;

   int      checks = 0;
   int      failures = 0;
   bit      rdy_rand = 1'b0;
   word_q_t out_q;
   word_q_t exp_q;
   word_q_t spec_frame;
   cfg_t    cfg;
   word_t   stall_data = '0;
   bit      stall = 1'b0;

   umtrx_packet_framer #(.BASE(BASE), .TTL(TTL)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clr           (clr),
      .set_stb       (set_stb),
      .set_addr      (set_addr),
      .set_data      (set_data),
      .vrt_inp_data  (vrt_inp_data),
      .vrt_inp_valid (vrt_inp_valid),
      .vrt_inp_ready (vrt_inp_ready),
      .eth_out_data  (eth_out_data),
      .eth_out_valid (eth_out_valid),
      .eth_out_ready (eth_out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      eth_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output collector; a stalled word must still be on the bus the next cycle.
   always @(negedge clk) begin
      if (stall && eth_out_valid && rst_n) begin
         checks++;
         if (eth_out_data !== stall_data) begin
            failures++;
            $display("FAIL hold_stable: got %h want %h", eth_out_data, stall_data);
         end
      end
      stall      = eth_out_valid && !eth_out_ready;
      stall_data = eth_out_data;
      if (eth_out_valid && eth_out_ready) out_q.push_back(eth_out_data);
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic word_q_t make_frame(input int nfield, input int len, input bit stray);
      word_q_t q;
      for (int i = 0; i < len; i++) begin
         word_t w;
         w[31:0]  = $urandom;
         w[35:34] = (i == len - 1) ? 2'($urandom_range(0, 3)) : 2'b00;
         w[33]    = (i == len - 1);
         w[32]    = (i == 0) ? 1'b1 : (stray && $urandom_range(0, 3) == 0);
         if (i == 0) w[15:0] = 16'(nfield);
         q.push_back(w);
      end
      return q;
   endfunction

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.src_ip   = $urandom;
      c.dst_ip   = $urandom;
      c.src_port = 16'($urandom);
      c.dst_port = 16'($urandom);
      c.src_mac  = {16'($urandom), 32'($urandom)};
      c.dst_mac  = {16'($urandom), 32'($urandom)};
      return c;
   endfunction

   // Expected framed output for one VRT frame; bad lengths produce nothing.
   function automatic void model(input word_q_t vrt, input cfg_t c);
      word_t       w0;
      int          n;
      int unsigned sum;
      logic [15:0] ip_len, udp_len, csum;
      w0 = vrt[0];
      n  = int'(w0[15:0]);
      if (n == 0 || n > 16376) return;
      ip_len  = 16'(28 + 4 * n);
      udp_len = 16'(8 + 4 * n);
      sum = 32'h4500 + 32'(ip_len) + 32'h0000 + 32'h4000 + 32'(TTL * 256 + 17)
          + 32'(c.src_ip[31:16]) + 32'(c.src_ip[15:0])
          + 32'(c.dst_ip[31:16]) + 32'(c.dst_ip[15:0]);
      while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
      csum = ~16'(sum);
      exp_q.push_back({4'b0001, 16'h0000, c.dst_mac[47:32]});
      exp_q.push_back({4'b0000, c.dst_mac[31:0]});
      exp_q.push_back({4'b0000, c.src_mac[47:16]});
      exp_q.push_back({4'b0000, c.src_mac[15:0], 16'h0800});
      exp_q.push_back({4'b0000, 16'h4500, ip_len});
      exp_q.push_back({4'b0000, 32'h0000_4000});
      exp_q.push_back({4'b0000, 8'(TTL), 8'h11, csum});
      exp_q.push_back({4'b0000, c.src_ip});
      exp_q.push_back({4'b0000, c.dst_ip});
      exp_q.push_back({4'b0000, c.src_port, c.dst_port});
      exp_q.push_back({4'b0000, udp_len, 16'h0000});
      foreach (vrt[i]) begin
         word_t w;
         w = vrt[i];
         w[32] = 1'b0;
         exp_q.push_back(w);
      end
   endfunction

   task automatic write_reg(input int off, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = 8'(BASE + off);
      set_data = d;
      @(posedge clk); #1;
      set_stb  = 1'b0;
   endtask

   task automatic program_cfg(input cfg_t c);
      write_reg(0, c.src_ip);
      write_reg(1, {c.src_port, c.dst_port});
      write_reg(2, c.dst_ip);
      write_reg(3, {16'h0000, c.src_mac[47:32]});
      write_reg(4, c.src_mac[31:0]);
      write_reg(5, {16'h0000, c.dst_mac[47:32]});
      write_reg(6, c.dst_mac[31:0]);
   endtask

   task automatic send_frame(input word_q_t w, input bit gaps, input string tag);
      int i = 0;
      int guard = 0;
      bit accepted;
      while (i < w.size() && guard < 5000) begin
         vrt_inp_data  = w[i];
         vrt_inp_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         accepted = vrt_inp_valid && vrt_inp_ready;
         @(posedge clk); #1;
         if (accepted) i++;
         guard++;
      end
      vrt_inp_valid = 1'b0;
      checks++;
      if (i != w.size()) begin
         failures++;
         $display("FAIL %s_consumed: got %0d words want %0d", tag, i, w.size());
      end
   endtask

   task automatic wait_out(input int n);
      int t = 0;
      while (out_q.size() < n && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (vrt_inp_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b want 1", vrt_inp_ready);
      end
      checks++;
      if (eth_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: got %b want 0", eth_out_valid);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_spec_vector();
      word_t w;
      cfg = rand_cfg();
      cfg.src_ip   = 32'hC0A8_0A02;
      cfg.dst_ip   = 32'hC0A8_0A01;
      cfg.src_port = 16'hC000;
      cfg.dst_port = 16'h07D0;
      program_cfg(cfg);
      out_q.delete();
      exp_q.delete();
      spec_frame = make_frame(4, 4, 1'b0);
      model(spec_frame, cfg);
      send_frame(spec_frame, 1'b0, "spec");
      wait_out(15);
      checks++;
      if (out_q.size() != 15) begin
         failures++;
         $display("FAIL spec_count: got %0d want 15", out_q.size());
      end else begin
         w = out_q[4];
         checks++;
         if (w[31:0] !== 32'h4500_002C) begin
            failures++;
            $display("FAIL spec_w4: got %h want 4500002c", w[31:0]);
         end
         w = out_q[6];
         checks++;
         if (w[31:0] !== 32'h4011_A56D) begin
            failures++;
            $display("FAIL spec_w6: got %h want 4011a56d", w[31:0]);
         end
         w = out_q[10];
         checks++;
         if (w[31:0] !== 32'h0018_0000) begin
            failures++;
            $display("FAIL spec_w10: got %h want 00180000", w[31:0]);
         end
         w = out_q[0];
         checks++;
         if (w[32] !== 1'b1) begin
            failures++;
            $display("FAIL spec_sof: got %b want 1", w[32]);
         end
         w = out_q[14];
         checks++;
         if (w[33] !== 1'b1) begin
            failures++;
            $display("FAIL spec_eof: got %b want 1", w[33]);
         end
         foreach (exp_q[i]) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL spec_word%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      word_q_t f;
      out_q.delete();
      exp_q.delete();
      rdy_rand = 1'b1;
      model(spec_frame, cfg);
      send_frame(spec_frame, 1'b1, "bp_spec");
      for (int k = 0; k < 3; k++) begin
         int len = $urandom_range(1, 12);
         f = make_frame(len, len, 1'b1);
         model(f, cfg);
         send_frame(f, 1'b1, "bp_rand");
      end
      wait_out(exp_q.size());
      rdy_rand = 1'b0;
      wait_out(exp_q.size());
      checks++;
      if (out_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL bp_count: got %0d want %0d", out_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL bp_word%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_bad_length();
      word_q_t f;
      int      nf[6] = '{0, 16'hFFFF, 0, 16377, 16376, 3};
      int      ln[6] = '{3, 5, 1, 2, 2, 3};
      out_q.delete();
      exp_q.delete();
      for (int k = 0; k < 6; k++) begin
         f = make_frame(nf[k], ln[k], 1'b1);
         model(f, cfg);
         send_frame(f, 1'b1, "badlen");
      end
      wait_out(exp_q.size());
      checks++;
      if (out_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL badlen_count: got %0d want %0d", out_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL badlen_word%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_single_word();
      word_q_t f;
      word_t   w;
      out_q.delete();
      exp_q.delete();
      f = make_frame(1, 1, 1'b0);
      model(f, cfg);
      send_frame(f, 1'b0, "single");
      wait_out(12);
      checks++;
      if (out_q.size() != 12) begin
         failures++;
         $display("FAIL single_count: got %0d want 12", out_q.size());
      end else begin
         w = out_q[4];
         checks++;
         if (w[15:0] !== 16'h0020) begin
            failures++;
            $display("FAIL single_iplen: got %h want 0020", w[15:0]);
         end
         w = out_q[11];
         checks++;
         if (w[33] !== 1'b1) begin
            failures++;
            $display("FAIL single_eof: got %b want 1", w[33]);
         end
         foreach (exp_q[i]) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL single_word%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_mid_write();
      word_q_t     fa, fb;
      logic [31:0] new_ip;
      out_q.delete();
      exp_q.delete();
      new_ip = $urandom;
      fa = make_frame(10, 10, 1'b1);
      fb = make_frame(3, 3, 1'b1);
      model(fa, cfg);
      fork
         begin
            send_frame(fa, 1'b0, "midwr_a");
            send_frame(fb, 1'b0, "midwr_b");
         end
         begin
            int t = 0;
            while (out_q.size() < 13 && t < 500) begin
               @(posedge clk); #1;
               t++;
            end
            write_reg(2, new_ip);
         end
      join
      cfg.dst_ip = new_ip;
      model(fb, cfg);
      wait_out(exp_q.size());
      checks++;
      if (out_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL midwr_count: got %0d want %0d", out_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL midwr_word%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_hdr();
      word_q_t f;
      out_q.delete();
      exp_q.delete();
      f = make_frame(4, 4, 1'b0);
      fork
         send_frame(f, 1'b0, "rsthdr_drop");
         begin
            int t = 0;
            while (out_q.size() != 5 && t < 500) begin
               @(posedge clk); #2;
               t++;
            end
            rst_n = 1'b0;
            #1;
            checks++;
            if (eth_out_valid !== 1'b0) begin
               failures++;
               $display("FAIL rsthdr_valid: got %b want 0", eth_out_valid);
            end
            @(posedge clk); #2;
            rst_n = 1'b1;
         end
      join
      wait_out(6);
      checks++;
      if (out_q.size() != 5) begin
         failures++;
         $display("FAIL rsthdr_leftover: got %0d words want 5", out_q.size());
      end
      cfg = rand_cfg();
      program_cfg(cfg);
      out_q.delete();
      f = make_frame(5, 5, 1'b1);
      model(f, cfg);
      send_frame(f, 1'b0, "rsthdr_next");
      wait_out(exp_q.size());
      checks++;
      if (out_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL rsthdr_count: got %0d want %0d", out_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL rsthdr_word%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_spec_vector();
      test_backpressure();
      test_bad_length();
      test_single_word();
      test_mid_write();
      test_reset_hdr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
